// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS Avalon-MM bus arbiter.
// The bus watchdog is built in when MIPS_BUS_WATCHDOG_EN is defined.
package mips_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      GNT_NONE  = 2'd0,
      GNT_INSTR = 2'd1,
      GNT_DATA  = 2'd2
   } grant_t;

   // Read data returned to the requester when an access is aborted
   localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

   // Avalon addresses are word aligned: the byte offset is carried by byteenable
   function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
      return {byte_addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/mips_bus_watchdog.sv
// Waitrequest watchdog for the bus arbiter. It counts stalled cycles of the
// current access and flags expiry once TIMEOUT_CYCLES cycles have been spent
// in BUS with waitrequest still high. It is only instantiated when
// MIPS_BUS_WATCHDOG_EN is defined.
module mips_bus_watchdog #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic waitrequest,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count_r;

   // Stall counter: held at zero outside BUS, advances on every stalled cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= {CW{1'b0}};
      end else if (clear) begin
         count_r <= {CW{1'b0}};
      end else if (waitrequest && (count_r != LAST_COUNT)) begin
         count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = !clear && waitrequest && (count_r == LAST_COUNT);

endmodule

// File: rtl/mips_bus_arbiter.sv
// Arbiter sharing the CPU's single Avalon-MM master between the fetch and
// load/store requesters. Data has fixed priority over fetch; each access goes
// IDLE -> BUS -> RESP with a one-cycle done pulse in RESP.
// Define MIPS_BUS_WATCHDOG_EN to abort accesses stalled for TIMEOUT_CYCLES.
module mips_bus_arbiter
   import mips_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_done,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic [31:0] d_rdata,
   output logic        d_done,
   output logic        bus_err,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   input  logic        waitrequest,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic [31:0] readdata
);

   arb_state_t  state_r;
   arb_state_t  state_nxt_s;
   grant_t      grant_r;
   logic [31:0] addr_r;
   logic        we_r;
   logic [31:0] wdata_r;
   logic [3:0]  be_r;
   logic        err_r;
   logic [31:0] i_rdata_r;
   logic [31:0] d_rdata_r;
   logic        expired_s;

`ifdef MIPS_BUS_WATCHDOG_EN
   mips_bus_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk        (clk),
      .rst        (rst),
      .clear      (state_r != BUS),
      .waitrequest(waitrequest),
      .expired    (expired_s)
   );
`else
   logic unused_timeout_s;
   assign unused_timeout_s = (TIMEOUT_CYCLES == 0);
   assign expired_s = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic: one access per IDLE visit, so back-to-back requests get an IDLE gap
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (d_req || i_req) begin
               state_nxt_s = BUS;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         BUS: begin
            if (!waitrequest || expired_s) begin
               state_nxt_s = RESP;
            end else begin
               state_nxt_s = BUS;
            end
         end
         RESP:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Strobes and done pulses decoded from the state and the latched request
   always_comb begin
      read    = 1'b0;
      write   = 1'b0;
      i_done  = 1'b0;
      d_done  = 1'b0;
      bus_err = 1'b0;
      case (state_r)
         BUS: begin
            read  = !we_r;
            write = we_r;
         end
         RESP: begin
            i_done  = (grant_r == GNT_INSTR);
            d_done  = (grant_r == GNT_DATA);
            bus_err = err_r;
         end
         default: begin
            read  = 1'b0;
            write = 1'b0;
         end
      endcase
   end

   // Request latch and read-data capture; requesters may change inputs mid-access
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_r   <= GNT_NONE;
         addr_r    <= 32'h0000_0000;
         we_r      <= 1'b0;
         wdata_r   <= 32'h0000_0000;
         be_r      <= 4'h0;
         err_r     <= 1'b0;
         i_rdata_r <= 32'h0000_0000;
         d_rdata_r <= 32'h0000_0000;
      end else begin
         case (state_r)
            IDLE: begin
               err_r <= 1'b0;
               if (d_req) begin
                  grant_r <= GNT_DATA;
                  addr_r  <= word_align(d_addr);
                  we_r    <= d_we;
                  wdata_r <= d_wdata;
                  be_r    <= d_be;
               end else if (i_req) begin
                  grant_r <= GNT_INSTR;
                  addr_r  <= word_align(i_addr);
                  we_r    <= 1'b0;
                  wdata_r <= 32'h0000_0000;
                  be_r    <= 4'hF;
               end else begin
                  grant_r <= grant_r;
               end
            end
            BUS: begin
               if (expired_s) begin
                  err_r <= 1'b1;
                  if (!we_r && (grant_r == GNT_INSTR)) begin
                     i_rdata_r <= BUS_ERR_DATA;
                  end else if (!we_r && (grant_r == GNT_DATA)) begin
                     d_rdata_r <= BUS_ERR_DATA;
                  end else begin
                     d_rdata_r <= d_rdata_r;
                  end
               end else if (!waitrequest && !we_r) begin
                  if (grant_r == GNT_INSTR) begin
                     i_rdata_r <= readdata;
                  end else if (grant_r == GNT_DATA) begin
                     d_rdata_r <= readdata;
                  end else begin
                     d_rdata_r <= d_rdata_r;
                  end
               end else begin
                  err_r <= err_r;
               end
            end
            default: begin
               err_r <= err_r;
            end
         endcase
      end
   end

   assign address    = addr_r;
   assign writedata  = wdata_r;
   assign byteenable = be_r;
   assign i_rdata    = i_rdata_r;
   assign d_rdata    = d_rdata_r;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed self-checking bench for mips_bus_arbiter. Inputs change and outputs
// are observed 2 time units after each rising clock edge.
module tb_mips_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_done;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        bus_err;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic        waitrequest;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [31:0] readdata;

   int total = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mips_bus_arbiter #(
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .i_rdata    (i_rdata),
      .i_done     (i_done),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_be       (d_be),
      .d_rdata    (d_rdata),
      .d_done     (d_done),
      .bus_err    (bus_err),
      .address    (address),
      .read       (read),
      .write      (write),
      .waitrequest(waitrequest),
      .writedata  (writedata),
      .byteenable (byteenable),
      .readdata   (readdata)
   );

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
      d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0; waitrequest = 1'b0; readdata = 32'h0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_read", {31'h0, read}, 32'h0);
      chk("rst_write", {31'h0, write}, 32'h0);
      chk("rst_address", address, 32'h0);
      chk("rst_writedata", writedata, 32'h0);
      chk("rst_be", {28'h0, byteenable}, 32'h0);
      chk("rst_done", {30'h0, i_done, d_done}, 32'h0);
      chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
      chk("rst_rdata", i_rdata | d_rdata, 32'h0);

      // 1: zero-wait fetch, unaligned byte address
      i_req = 1'b1; i_addr = 32'h0000_1003; readdata = 32'h2402_0005;
      tick();
      chk("t1_read", {31'h0, read}, 32'h1);
      chk("t1_write", {31'h0, write}, 32'h0);
      chk("t1_address", address, 32'h0000_1000);
      chk("t1_be", {28'h0, byteenable}, 32'hF);
      chk("t1_early_done", {31'h0, i_done}, 32'h0);
      tick();
      chk("t1_i_done", {31'h0, i_done}, 32'h1);
      chk("t1_i_rdata", i_rdata, 32'h2402_0005);
      chk("t1_read_off", {31'h0, read}, 32'h0);
      i_req = 1'b0;
      tick();
      chk("t1_done_once", {31'h0, i_done}, 32'h0);

      // 2: simultaneous requests, data write wins
      i_req = 1'b1; i_addr = 32'h0000_0040; readdata = 32'h1111_2222;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hCAFE_F00D; d_be = 4'b0011;
      tick();
      chk("t2_write", {31'h0, write}, 32'h1);
      chk("t2_no_read", {31'h0, read}, 32'h0);
      chk("t2_address", address, 32'h20);
      chk("t2_wdata", writedata, 32'hCAFE_F00D);
      chk("t2_be", {28'h0, byteenable}, 32'h3);
      tick();
      chk("t2_d_done", {31'h0, d_done}, 32'h1);
      chk("t2_i_done_not", {31'h0, i_done}, 32'h0);
      chk("t2_write_off", {31'h0, write}, 32'h0);
      chk("t2_d_rdata_kept", d_rdata, 32'h0);
      d_req = 1'b0; d_we = 1'b0;
      tick();
      chk("t2_gap_idle", {30'h0, read, write}, 32'h0);
      tick();
      chk("t2_fetch_read", {31'h0, read}, 32'h1);
      chk("t2_fetch_addr", address, 32'h40);
      chk("t2_fetch_be", {28'h0, byteenable}, 32'hF);
      tick();
      chk("t2_i_done", {31'h0, i_done}, 32'h1);
      chk("t2_i_rdata", i_rdata, 32'h1111_2222);
      chk("t2_d_done_off", {31'h0, d_done}, 32'h0);
      i_req = 1'b0;
      tick();

      // 3: data read with 3 waitrequest cycles; requester fields change mid-access
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h84; d_be = 4'b1100; waitrequest = 1'b1;
      readdata = 32'h5555_5555;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("t3_read_c%0d", k), {31'h0, read}, 32'h1);
         chk($sformatf("t3_addr_c%0d", k), address, 32'h84);
         chk($sformatf("t3_be_c%0d", k), {28'h0, byteenable}, 32'hC);
         chk($sformatf("t3_nodone_c%0d", k), {31'h0, d_done}, 32'h0);
         d_addr = 32'h0000_0FFF; d_be = 4'b0001;
         if (k == 4) begin
            waitrequest = 1'b0; readdata = 32'hABCD_1234;
         end
      end
      tick();
      chk("t3_d_done", {31'h0, d_done}, 32'h1);
      chk("t3_d_rdata", d_rdata, 32'hABCD_1234);
      chk("t3_i_rdata_kept", i_rdata, 32'h1111_2222);
      d_req = 1'b0;
      tick();

      // 4: reset during a stalled access
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF; waitrequest = 1'b1;
      tick();
      chk("t4_read_before", {31'h0, read}, 32'h1);
      rst = 1'b1;
      tick();
      chk("t4_read_after", {31'h0, read}, 32'h0);
      chk("t4_no_done", {30'h0, i_done, d_done}, 32'h0);
      chk("t4_addr_cleared", address, 32'h0);
      rst = 1'b0; d_req = 1'b0; waitrequest = 1'b0;
      tick();
      chk("t4_idle_read", {30'h0, read, write}, 32'h0);
      chk("t4_idle_done", {30'h0, i_done, d_done}, 32'h0);
      tick();
      chk("t4_still_idle", {30'h0, i_done, d_done}, 32'h0);

`ifdef MIPS_BUS_WATCHDOG_EN
      // 5: stuck waitrequest aborted after 8 BUS cycles
      i_req = 1'b1; i_addr = 32'h200; waitrequest = 1'b1;
      tick();
      for (int k = 1; k <= 8; k++) begin
         chk($sformatf("t5_read_c%0d", k), {31'h0, read}, 32'h1);
         chk($sformatf("t5_noerr_c%0d", k), {30'h0, bus_err, i_done}, 32'h0);
         tick();
      end
      chk("t5_read_drop", {31'h0, read}, 32'h0);
      chk("t5_i_done", {31'h0, i_done}, 32'h1);
      chk("t5_bus_err", {31'h0, bus_err}, 32'h1);
      chk("t5_i_rdata", i_rdata, 32'hDEAD_BEEF);
      i_req = 1'b0; waitrequest = 1'b0;
      tick();
      chk("t5_err_once", {30'h0, bus_err, i_done}, 32'h0);
`else
      // 5: without the watchdog a stuck access just waits
      i_req = 1'b1; i_addr = 32'h200; waitrequest = 1'b1; readdata = 32'h7777_0000;
      tick();
      for (int k = 1; k <= 20; k++) begin
         chk($sformatf("t5_wait_c%0d", k), {29'h0, read, bus_err, i_done}, 32'h4);
         tick();
      end
      waitrequest = 1'b0;
      tick();
      chk("t5_i_done", {31'h0, i_done}, 32'h1);
      chk("t5_bus_err", {31'h0, bus_err}, 32'h0);
      chk("t5_i_rdata", i_rdata, 32'h7777_0000);
      i_req = 1'b0;
      tick();
`endif

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Shares the CPU's single Avalon-MM master port between the instruction-fetch requester and the load/store (data) requester.
- Sequences each access: grant, hold through waitrequest, capture readdata, one-cycle done pulse.
- Sits between the CPU core's fetch/memory stages and the top-level Avalon bus.

Parameters:
- TIMEOUT_CYCLES, 256, waitrequest cycles tolerated before abort (used only with watchdog macro).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- i_req  input  1  fetch request, held until i_done
- i_addr  input  32  fetch byte address
- i_rdata  output  32  fetched word, valid when i_done=1
- i_done  output  1  one-cycle completion pulse to fetch
- d_req  input  1  data request, held until d_done
- d_we  input  1  1 = write, 0 = read
- d_addr  input  32  data byte address
- d_wdata  input  32  write data
- d_be  input  4  byte enables
- d_rdata  output  32  load word, valid when d_done=1
- d_done  output  1  one-cycle completion pulse to data
- bus_err  output  1  one-cycle pulse with done on watchdog abort
- address  output  32  Avalon address, bits [1:0] forced to 0
- read  output  1  Avalon read
- write  output  1  Avalon write
- waitrequest  input  1  Avalon stall
- writedata  output  32  Avalon write data
- byteenable  output  4  Avalon byte enables
- readdata  input  32  Avalon read data, valid when read=1 and waitrequest=0

Behaviour:
- Reset: read, write, i_done, d_done and bus_err are 0; address, writedata, byteenable, i_rdata and d_rdata are 0; state is IDLE, grant is NONE.
- States:
  - IDLE: sample requests. d_req wins over i_req (fixed priority). The winner's fields (addr, we, wdata, be; fetch uses we=0, be=4'hF) are latched into internal registers. Go to BUS. No request: stay in IDLE.
  - BUS: read/write/address/writedata/byteenable are driven from the latched copy and held stable while waitrequest=1. On the first cycle with waitrequest=0, capture readdata into the granted requester's rdata (reads only) and go to RESP.
  - RESP: all bus strobes are 0. Pulse done for the granted requester for exactly 1 cycle. Go to IDLE.
- Latency: request sampled in IDLE at cycle N, strobe high at N+1, done at N+2 for zero wait states; each waitrequest cycle adds 1.
- Simultaneous i_req and d_req: data is served first and fetch immediately after, with 1 IDLE cycle between accesses.
- Write: rdata is unchanged and done still pulses.
- Requester dropping req or changing fields mid-access: the latched copy is used and the access completes normally.
- rst asserted in any state: next edge returns to IDLE, strobes drop, no done pulse, the latched request is discarded.
- read and write are never both 1. At most one done pulse per access.

Optional Feature:
- Macro: MIPS_BUS_WATCHDOG_EN.
- With the macro: a counter clears on entry to BUS and increments each cycle waitrequest=1. When the count reaches TIMEOUT_CYCLES-1 with waitrequest still 1:
  - strobes drop and the FSM goes to RESP;
  - done and bus_err pulse together;
  - read rdata is set to 32'hDEADBEEF.
- Without the macro: bus_err is tied to 0 and the arbiter waits indefinitely.

Decomposition:
- Package mips_bus_pkg holds:
  - arb_state_t enum {IDLE, BUS, RESP};
  - grant_t enum {GNT_NONE, GNT_INSTR, GNT_DATA};
  - constant BUS_ERR_DATA = 32'hDEADBEEF.
- One natural sub-module: mips_bus_watchdog (counter plus expiry flag), instantiated only under MIPS_BUS_WATCHDOG_EN.

Test Plan:
1. i_req with i_addr=32'h0000_1003 and zero-wait memory returning 32'h2402_0005: address=32'h0000_1000 and read=1 at N+1; i_done=1 at N+2 with i_rdata=32'h2402_0005.
2. i_req and d_req (write, d_addr=32'h20, d_wdata=32'hCAFEF00D, d_be=4'b0011) together: write served first with byteenable=4'b0011 and d_done pulses; fetch read follows, then i_done.
3. waitrequest held 3 cycles during a data read: read, address and byteenable stay stable for 4 cycles; d_done 1 cycle after waitrequest falls; d_rdata equals readdata from that cycle.
4. rst asserted while in BUS with waitrequest=1: next cycle read=0 and state is IDLE; no d_done or i_done pulse.
5. With MIPS_BUS_WATCHDOG_EN and TIMEOUT_CYCLES=8, waitrequest stuck at 1: read drops after 8 BUS cycles; i_done=1 and bus_err=1 together; i_rdata=32'hDEADBEEF.
